// File: rtl/ccu_ctrl_snoop_seq.sv
// ccu_ctrl_snoop_seq
//
// Snoop sequencer between the CCU main FSM and the snoop-response unit. For one coherent read it
// sends an AC snoop to every port except the initiator and collects each CR response. It then
// hands the response unit a decided operation (forward data or invalid-ack) with shared/dirty
// flags. It steers exactly one port's CD beats into the unit CD FIFO and sinks the CD beats of
// every other port that owes data.
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   start_valid_i/ready_o      sequence request from the CCU FSM; start_init_i = initiator
//   ac_valid_o/ac_ready_i      per-port snoop address handshake
//   cr_valid_i/cr_ready_o      per-port snoop response handshake, cr_resp_i = 5 bits per port
//                              ([0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared,
//                              [4] WasUnique)
//   cd_valid_i/cd_ready_o      per-port snoop data handshake
//   cd_sel_o, cd_handshake_o   mux select and push strobe into the unit CD FIFO
//   cd_fifo_full_i             unit CD FIFO full
//   su_req_o/su_gnt_i          request/grant to the snoop-response unit
//   su_op_o                    0 = READ_SNP_DATA, 1 = SEND_INVALID_ACK_R
//   shared_o, dirty_o          accumulated IsShared / PassDirty
//   busy_o                     sequence in progress
module ccu_ctrl_snoop_seq #(
  parameter int unsigned NoMstPorts      = 4,
  parameter int unsigned DcacheLineWords = 2,
  localparam int unsigned MstIdxBits     = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_valid_i,
  output logic                    start_ready_o,
  input  logic [MstIdxBits-1:0]   start_init_i,
  output logic [NoMstPorts-1:0]   ac_valid_o,
  input  logic [NoMstPorts-1:0]   ac_ready_i,
  input  logic [NoMstPorts-1:0]   cr_valid_i,
  output logic [NoMstPorts-1:0]   cr_ready_o,
  input  logic [5*NoMstPorts-1:0] cr_resp_i,
  input  logic [NoMstPorts-1:0]   cd_valid_i,
  output logic [NoMstPorts-1:0]   cd_ready_o,
  output logic [MstIdxBits-1:0]   cd_sel_o,
  output logic                    cd_handshake_o,
  input  logic                    cd_fifo_full_i,
  output logic                    su_req_o,
  input  logic                    su_gnt_i,
  output logic                    su_op_o,
  output logic                    shared_o,
  output logic                    dirty_o,
  output logic                    busy_o
);

  localparam int unsigned CntBits = $clog2(DcacheLineWords);
  localparam logic [CntBits-1:0] LastBeat = CntBits'(DcacheLineWords - 1);

  typedef enum logic [2:0] {StIdle, StSnoop, StIssue, StFwd, StDrain} state_e;

  state_e                                 state_q, state_d;
  logic [NoMstPorts-1:0]                  target_q, target_d;
  logic [NoMstPorts-1:0]                  ac_done_q, ac_done_d;
  logic [NoMstPorts-1:0]                  cr_done_q, cr_done_d;
  logic [NoMstPorts-1:0]                  data_mask_q, data_mask_d;
  logic [NoMstPorts-1:0]                  drain_mask_q, drain_mask_d;
  logic                                   shared_q, shared_d;
  logic                                   dirty_q, dirty_d;
  logic                                   op_q, op_d;
  logic [MstIdxBits-1:0]                  sel_q, sel_d;
  logic [CntBits-1:0]                     beat_cnt_q, beat_cnt_d;
  logic [NoMstPorts-1:0][CntBits-1:0]     drain_cnt_q, drain_cnt_d;

  logic [NoMstPorts-1:0] cr_hs;
  logic [NoMstPorts-1:0] sel_oh;
  logic                  result_valid;

  // WasUnique is carried on the bus but does not affect the decision.
  logic [5*NoMstPorts-1:0] unused_cr_resp;
  assign unused_cr_resp = cr_resp_i;

  assign sel_oh = NoMstPorts'(1) << sel_q;

  // Decision outputs are only meaningful from ISSUE entry until the return to IDLE.
  assign result_valid = (state_q == StIssue) || (state_q == StFwd) || (state_q == StDrain);
  assign su_op_o      = op_q & result_valid;
  assign shared_o     = shared_q & result_valid;
  assign dirty_o      = dirty_q & result_valid;
  assign busy_o       = (state_q != StIdle);

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    ac_done_d      = ac_done_q;
    cr_done_d      = cr_done_q;
    data_mask_d    = data_mask_q;
    drain_mask_d   = drain_mask_q;
    shared_d       = shared_q;
    dirty_d        = dirty_q;
    op_d           = op_q;
    sel_d          = sel_q;
    beat_cnt_d     = beat_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    cr_hs          = '0;
    start_ready_o  = 1'b0;
    ac_valid_o     = '0;
    cr_ready_o     = '0;
    cd_ready_o     = '0;
    cd_sel_o       = '0;
    cd_handshake_o = 1'b0;
    su_req_o       = 1'b0;

    unique case (state_q)
      StIdle: begin
        start_ready_o = 1'b1;
        if (start_valid_i) begin
          for (int i = 0; i < NoMstPorts; i++) begin
            target_d[i] = (MstIdxBits'(i) != start_init_i);
          end
          ac_done_d    = '0;
          cr_done_d    = '0;
          data_mask_d  = '0;
          drain_mask_d = '0;
          shared_d     = 1'b0;
          dirty_d      = 1'b0;
          beat_cnt_d   = '0;
          drain_cnt_d  = '0;
          // Single-port system: nobody to snoop, answer with an invalid-ack.
          if (target_d == '0) begin
            op_d    = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StSnoop;
          end
        end
      end

      StSnoop: begin
        ac_valid_o = target_q & ~ac_done_q;
        // Registered ac_done keeps a CR from being taken in its own AC handshake cycle.
        cr_ready_o = ac_done_q & ~cr_done_q;
        ac_done_d  = ac_done_q | (ac_valid_o & ac_ready_i);
        cr_hs      = cr_ready_o & cr_valid_i;
        for (int i = 0; i < NoMstPorts; i++) begin
          if (cr_hs[i]) begin
            cr_done_d[i] = 1'b1;
            if (cr_resp_i[5*i+3]) shared_d = 1'b1;
            if (cr_resp_i[5*i] && !cr_resp_i[5*i+1]) begin
              data_mask_d[i] = 1'b1;
              if (cr_resp_i[5*i+2]) dirty_d = 1'b1;
            end
            // Errored data still has to be pulled off the CD channel and thrown away.
            if (cr_resp_i[5*i] && cr_resp_i[5*i+1]) drain_mask_d[i] = 1'b1;
          end
        end
        if (cr_done_q == target_q) begin
          op_d = (data_mask_q == '0);
          for (int i = int'(NoMstPorts) - 1; i >= 0; i--) begin
            if (data_mask_q[i]) sel_d = MstIdxBits'(i);
          end
          state_d = StIssue;
        end
      end

      StIssue: begin
        su_req_o = 1'b1;
        if (su_gnt_i) begin
          if (!op_q) begin
            beat_cnt_d = '0;
            state_d    = StFwd;
          end else if (drain_mask_q != '0) begin
            state_d = StDrain;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StFwd: begin
        cd_sel_o          = sel_q;
        cd_ready_o[sel_q] = ~cd_fifo_full_i;
        cd_handshake_o    = cd_valid_i[sel_q] & ~cd_fifo_full_i;
        if (cd_handshake_o) begin
          if (beat_cnt_q == LastBeat) begin
            // Other clean suppliers owe a line too; sink it after the forward.
            drain_mask_d = drain_mask_q | (data_mask_q & ~sel_oh);
            beat_cnt_d   = '0;
            state_d      = (drain_mask_d != '0) ? StDrain : StIdle;
          end else begin
            beat_cnt_d = beat_cnt_q + CntBits'(1);
          end
        end
      end

      StDrain: begin
        cd_ready_o = drain_mask_q;
        for (int i = 0; i < NoMstPorts; i++) begin
          if (drain_mask_q[i] && cd_valid_i[i]) begin
            if (drain_cnt_q[i] == LastBeat) begin
              drain_mask_d[i] = 1'b0;
              drain_cnt_d[i]  = '0;
            end else begin
              drain_cnt_d[i] = drain_cnt_q[i] + CntBits'(1);
            end
          end
        end
        if (drain_mask_d == '0) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      target_q     <= '0;
      ac_done_q    <= '0;
      cr_done_q    <= '0;
      data_mask_q  <= '0;
      drain_mask_q <= '0;
      shared_q     <= 1'b0;
      dirty_q      <= 1'b0;
      op_q         <= 1'b0;
      sel_q        <= '0;
      beat_cnt_q   <= '0;
      drain_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      ac_done_q    <= ac_done_d;
      cr_done_q    <= cr_done_d;
      data_mask_q  <= data_mask_d;
      drain_mask_q <= drain_mask_d;
      shared_q     <= shared_d;
      dirty_q      <= dirty_d;
      op_q         <= op_d;
      sel_q        <= sel_d;
      beat_cnt_q   <= beat_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

endmodule
